// File: rtl/display_timing_gen_if.sv
// Scan-timing bundle between the timing generator and the pixel pipeline.
// The generator takes the master view, the consumer (block_controller) the slave view.
interface display_timing_gen_if;
  logic       en;
  logic       pix_tick;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       hSync;
  logic       vSync;
  logic       bright;
  logic       frame_start;
  logic       move_tick;

  modport master (
    input  en,
    output pix_tick, hCount, vCount, hSync, vSync, bright, frame_start, move_tick
  );

  modport slave (
    output en,
    input  pix_tick, hCount, vCount, hSync, vSync, bright, frame_start, move_tick
  );
endinterface

// File: rtl/display_timing_gen.sv
// Display scan timing generator: pixel clock-enable divider, h/v scan counters,
// registered sync/blanking aligned to the counters, frame and move-rate pulses.
// Everything runs on the system clock; the pixel rate is a clock enable.
module display_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_BEG   = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_BEG   = 35,
  parameter int V_ACT_END   = 516,
  parameter int MOVE_FRAMES = 4
) (
  input  logic                clk,
  input  logic                rst,
  display_timing_gen_if.master bus
);

  localparam int DW = $clog2(CLK_DIV);
  // A one-frame move rate still needs a 1-bit counter that simply stays at 0.
  localparam int FW = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [FW-1:0] F_LAST   = FW'(MOVE_FRAMES - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_SYN    = 10'(H_SYNC);
  localparam logic [9:0]    V_SYN    = 10'(V_SYNC);
  localparam logic [9:0]    H_BEG    = 10'(H_ACT_BEG);
  localparam logic [9:0]    H_END    = 10'(H_ACT_END);
  localparam logic [9:0]    V_BEG    = 10'(V_ACT_BEG);
  localparam logic [9:0]    V_END    = 10'(V_ACT_END);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          pix_tick_q, pix_tick_d;
  logic          frame_start_q, frame_start_d;
  logic          move_tick_q, move_tick_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          bright_q, bright_d;

  logic adv;
  logic wrap;

  // Next-state: divider, scan counters, frame counter, and sync/blank decoded
  // from the next counter values so they line up with hCount/vCount.
  always_comb begin
    adv           = bus.en && (div_q == DIV_LAST);
    wrap          = adv && (h_q == H_LAST) && (v_q == V_LAST);
    div_d         = div_q;
    h_d           = h_q;
    v_d           = v_q;
    frame_cnt_d   = frame_cnt_q;
    pix_tick_d    = adv;
    frame_start_d = wrap;
    move_tick_d   = wrap && (frame_cnt_q == F_LAST);

    if (bus.en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end

    if (adv) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    if (wrap) begin
      frame_cnt_d = (frame_cnt_q == F_LAST) ? '0 : frame_cnt_q + FW'(1);
    end

    // With en low h_d/v_d equal the held counters, so these hold too.
    hsync_d  = !(h_d < H_SYN);
    vsync_d  = !(v_d < V_SYN);
    bright_d = (h_d >= H_BEG) && (h_d < H_END) && (v_d >= V_BEG) && (v_d < V_END);
  end

  // State registers; reset parks the scan at (0,0), inside both sync pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      frame_cnt_q   <= '0;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
      move_tick_q   <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      bright_q      <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_cnt_q   <= frame_cnt_d;
      pix_tick_q    <= pix_tick_d;
      frame_start_q <= frame_start_d;
      move_tick_q   <= move_tick_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      bright_q      <= bright_d;
    end
  end

  assign bus.pix_tick    = pix_tick_q;
  assign bus.hCount      = h_q;
  assign bus.vCount      = v_q;
  assign bus.hSync       = hsync_q;
  assign bus.vSync       = vsync_q;
  assign bus.bright      = bright_q;
  assign bus.frame_start = frame_start_q;
  assign bus.move_tick   = move_tick_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// Directed bench for display_timing_gen on a shrunken raster (20x10 pixels,
// CLK_DIV=4, so one frame is 800 clks) to keep multi-frame runs short.
module tb_display_timing_gen;
  localparam int CLK_DIV = 4;
  localparam int H_TOT   = 20;
  localparam int V_TOT   = 10;
  localparam int FRAME   = H_TOT * V_TOT * CLK_DIV;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  display_timing_gen_if dif();

  display_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOT), .H_SYNC(3), .H_ACT_BEG(5), .H_ACT_END(17),
    .V_TOTAL(V_TOT), .V_SYNC(2), .V_ACT_BEG(3), .V_ACT_END(8), .MOVE_FRAMES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // First clk at which the scan reads (h,v), i.e. the pix_tick cycle.
  task automatic wait_px(input int h, input int v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (dif.pix_tick && dif.hCount == 10'(h) && dif.vCount == 10'(v)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk); #1;
      if (dif.frame_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int cnt;
    int prev;
    logic any;
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    dif.en = 1'b1;

    // Reset held 3 clks, released with en high.
    step(3);
    rst = 1'b0;
    chk("rst_hcount", dif.hCount, 0);
    chk("rst_vcount", dif.vCount, 0);
    chk("rst_pix",    dif.pix_tick, 0);
    chk("rst_fs",     dif.frame_start, 0);
    chk("rst_mt",     dif.move_tick, 0);
    chk("rst_bright", dif.bright, 0);
    chk("rst_hsync",  dif.hSync, 0);
    chk("rst_vsync",  dif.vSync, 0);
    step(1);
    chk("leave_rst_fs", dif.frame_start, 0);
    step(2);
    chk("pix_early", dif.pix_tick, 0);
    chk("h_early",   dif.hCount, 0);
    step(1);
    chk("first_pix", dif.pix_tick, 1);
    chk("first_h",   dif.hCount, 1);
    step(1);
    chk("pix_width", dif.pix_tick, 0);

    // Line wrap and hSync width.
    wait_px(H_TOT - 1, 0, ok);
    chk("reach_eol", ok, 1);
    step(CLK_DIV);
    chk("wrap_h", dif.hCount, 0);
    chk("wrap_v", dif.vCount, 1);
    chk("wrap_pix", dif.pix_tick, 1);
    cnt = 0;
    for (int i = 0; i < 200 && !dif.hSync; i++) begin
      cnt++;
      step(1);
    end
    chk("hsync_low_clks", cnt, 3 * CLK_DIV);

    // vSync low only for lines 0..1.
    wait_px(H_TOT - 1, 1, ok);
    chk("reach_19_1", ok, 1);
    chk("vsync_line1", dif.vSync, 0);
    step(CLK_DIV);
    chk("vsync_line2", dif.vSync, 1);
    chk("hsync_h0", dif.hSync, 0);

    // Active-window edges on the first visible line.
    wait_px(4, 3, ok);
    chk("reach_4_3", ok, 1);
    chk("bright_h4", dif.bright, 0);
    step(CLK_DIV);
    chk("bright_h5", dif.bright, 1);
    wait_px(16, 3, ok);
    chk("reach_16_3", ok, 1);
    chk("bright_h16", dif.bright, 1);
    step(CLK_DIV);
    chk("bright_h17", dif.bright, 0);

    // Line V_ACT_END is fully blank.
    wait_px(0, 8, ok);
    chk("reach_0_8", ok, 1);
    any = 1'b0;
    for (int i = 0; i < H_TOT * CLK_DIV; i++) begin
      any = any | dif.bright;
      step(1);
    end
    chk("bright_line8", any, 0);

    // Nine frames: spacing, pulse shape, move_tick on the 4th and 8th only.
    prev = 0;
    for (int k = 1; k <= 9; k++) begin
      wait_fs(ok);
      chk("fs_seen", ok, 1);
      chk("fs_h", dif.hCount, 0);
      chk("fs_v", dif.vCount, 0);
      chk("mt_pattern", dif.move_tick, (k % 4 == 0) ? 1 : 0);
      if (k > 1) chk("fs_spacing", cyc - prev, FRAME);
      prev = cyc;
      step(1);
      chk("fs_width", dif.frame_start, 0);
    end

    // Pause exactly when the divider would fire; everything must hold.
    wait_px(10, 4, ok);
    chk("reach_10_4", ok, 1);
    step(CLK_DIV - 1);
    dif.en = 1'b0;
    any = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      any = any | dif.pix_tick | dif.frame_start | dif.move_tick;
      if (dif.hCount != 10'd10 || dif.vCount != 10'd4 || !dif.bright) cnt++;
    end
    chk("pause_pulses", any, 0);
    chk("pause_hold_err", cnt, 0);
    dif.en = 1'b1;
    step(1);
    chk("resume_h", dif.hCount, 11);
    chk("resume_pix", dif.pix_tick, 1);

    // Async reset mid-frame at an active pixel.
    wait_px(15, 6, ok);
    chk("reach_15_6", ok, 1);
    chk("pre_rst_bright", dif.bright, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_h",      dif.hCount, 0);
    chk("async_v",      dif.vCount, 0);
    chk("async_bright", dif.bright, 0);
    chk("async_hsync",  dif.hSync, 0);
    chk("async_vsync",  dif.vSync, 0);
    chk("async_pix",    dif.pix_tick, 0);
    step(2);
    rst = 1'b0;
    step(CLK_DIV);
    chk("restart_h", dif.hCount, 1);
    chk("restart_v", dif.vCount, 0);
    // frame_cnt restarted: move_tick only on the 4th frame_start after reset.
    for (int k = 1; k <= 4; k++) begin
      wait_fs(ok);
      chk("rfs_seen", ok, 1);
      chk("rmt_pattern", dif.move_tick, (k == 4) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
